// File: rtl/mult_pipe_regs.sv
// Multiply-result pipeline of STAGES slots with valid/regwrite tracking, hazard lookup and occupancy; latency STAGES-1 edges.
// No ready/valid backpressure: we=0 freezes every slot and the outputs, flush squashes all slots, reset clears everything asynchronously.
module mult_pipe_regs #(
   parameter int REG_SIZE = 32,
   parameter int REG_ADDR = 5,
   parameter int STAGES   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         we,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic                         regwrite_mult_in,
   input  logic [REG_ADDR-1:0]          wreg_in,
   input  logic [REG_SIZE-1:0]          pre_result,
   input  logic                         pre_zero,
   input  logic                         pre_overflow,
   input  logic [REG_ADDR-1:0]          src_a,
   input  logic [REG_ADDR-1:0]          src_b,
   output logic                         out_valid,
   output logic                         regwrite_out,
   output logic                         zero,
   output logic                         overflow,
   output logic [REG_SIZE-1:0]          m_result,
   output logic [REG_ADDR-1:0]          dst_reg,
   output logic                         hazard,
   output logic [$clog2(STAGES+1)-1:0]  occupancy
);

   localparam int OCC_W = $clog2(STAGES + 1);

   generate
      if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
         $error("mult_pipe_regs: STAGES must be within 2..8");
      end
   endgenerate

   logic [STAGES-1:0]   valid_q;
   logic [STAGES-1:0]   regwrite_q;
   logic [STAGES-1:0]   zero_q;
   logic [STAGES-1:0]   overflow_q;
   logic [REG_SIZE-1:0] result_q [STAGES];
   logic [REG_ADDR-1:0] dst_q    [STAGES];
   logic [OCC_W-1:0]    occ_q;
   logic [OCC_W-1:0]    occ_next;
   logic                hazard_c;

   // Entry and retire are both single-bit, so the count moves by at most one per advance.
   always_comb begin
      occ_next = occ_q + OCC_W'(in_valid) - OCC_W'(valid_q[STAGES-1]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= '0;
         regwrite_q <= '0;
         zero_q     <= '0;
         overflow_q <= '0;
         occ_q      <= '0;
         for (int k = 0; k < STAGES; k++) begin
            result_q[k] <= '0;
            dst_q[k]    <= '0;
         end
      end else if (flush) begin
         valid_q    <= '0;
         regwrite_q <= '0;
         occ_q      <= '0;
      end else if (we) begin
         valid_q     <= {valid_q[STAGES-2:0], in_valid};
         regwrite_q  <= {regwrite_q[STAGES-2:0], regwrite_mult_in & in_valid};
         zero_q      <= {zero_q[STAGES-2:0], pre_zero};
         overflow_q  <= {overflow_q[STAGES-2:0], pre_overflow};
         result_q[0] <= pre_result;
         dst_q[0]    <= wreg_in;
         for (int k = 1; k < STAGES; k++) begin
            result_q[k] <= result_q[k-1];
            dst_q[k]    <= dst_q[k-1];
         end
         occ_q <= occ_next;
      end
   end

   // Register 0 is hardwired, so it never creates a dependency.
   always_comb begin
      hazard_c = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (valid_q[k] && regwrite_q[k] && (dst_q[k] != '0) &&
             ((dst_q[k] == src_a) || (dst_q[k] == src_b))) begin
            hazard_c = 1'b1;
         end
      end
   end

   assign out_valid    = valid_q[STAGES-1];
   assign regwrite_out = valid_q[STAGES-1] & regwrite_q[STAGES-1];
   assign zero         = zero_q[STAGES-1];
   assign overflow     = overflow_q[STAGES-1];
   assign m_result     = result_q[STAGES-1];
   assign dst_reg      = dst_q[STAGES-1];
   assign hazard       = hazard_c;
   assign occupancy    = occ_q;

   occ_bounded_a: assert property (@(posedge clk) disable iff (!reset)
      occ_q <= OCC_W'(STAGES));
   occ_tracks_valid_a: assert property (@(posedge clk) disable iff (!reset)
      occ_q == OCC_W'($countones(valid_q)));

endmodule

// File: tb/tb_mult_pipe_regs.sv
// Directed bench for mult_pipe_regs: queue-based reference model compared every cycle, plus literal expectations.
module tb_mult_pipe_regs;
   localparam int STAGES = 4;
   localparam int RS     = 32;
   localparam int RA     = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          we = 1'b0, flush = 1'b0, in_valid = 1'b0, regwrite_mult_in = 1'b0;
   logic          pre_zero = 1'b0, pre_overflow = 1'b0;
   logic [RA-1:0] wreg_in = '0, src_a = '0, src_b = '0;
   logic [RS-1:0] pre_result = '0;
   logic          out_valid, regwrite_out, zero, overflow, hazard;
   logic [RS-1:0] m_result;
   logic [RA-1:0] dst_reg;
   logic [2:0]    occupancy;

   int checks = 0;
   int passes = 0;

   mult_pipe_regs #(.REG_SIZE(RS), .REG_ADDR(RA), .STAGES(STAGES)) dut (
      .clk(clk), .reset(reset), .we(we), .flush(flush), .in_valid(in_valid),
      .regwrite_mult_in(regwrite_mult_in), .wreg_in(wreg_in), .pre_result(pre_result),
      .pre_zero(pre_zero), .pre_overflow(pre_overflow), .src_a(src_a), .src_b(src_b),
      .out_valid(out_valid), .regwrite_out(regwrite_out), .zero(zero), .overflow(overflow),
      .m_result(m_result), .dst_reg(dst_reg), .hazard(hazard), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic          rw;
      logic [RA-1:0] dst;
      logic [RS-1:0] res;
      logic          z;
      logic          ov;
   } ent_t;

   // Index 0 is the newest instruction, index STAGES-1 is the one at the outputs.
   ent_t mq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic mdl_hazard();
      logic h = 1'b0;
      foreach (mq[i])
         if (mq[i].v && mq[i].rw && mq[i].dst != 0 && (mq[i].dst == src_a || mq[i].dst == src_b))
            h = 1'b1;
      return h;
   endfunction

   function automatic logic [63:0] mdl_occ();
      int n = 0;
      foreach (mq[i]) if (mq[i].v) n++;
      return 64'(n);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         for (int i = 0; i < STAGES; i++) mq.push_back('0);
      end else if (flush) begin
         foreach (mq[i]) begin
            mq[i].v  = 1'b0;
            mq[i].rw = 1'b0;
         end
      end else if (we) begin
         ent_t e;
         e.v   = in_valid;
         e.rw  = regwrite_mult_in & in_valid;
         e.dst = wreg_in;
         e.res = pre_result;
         e.z   = pre_zero;
         e.ov  = pre_overflow;
         mq.push_front(e);
         void'(mq.pop_back());
      end
   end

   always @(negedge clk) begin
      ent_t e;
      e = mq[STAGES-1];
      chk("out_valid", out_valid, e.v);
      chk("regwrite_out", regwrite_out, e.v & e.rw);
      chk("zero", zero, e.z);
      chk("overflow", overflow, e.ov);
      chk("m_result", m_result, e.res);
      chk("dst_reg", dst_reg, e.dst);
      chk("hazard", hazard, mdl_hazard());
      chk("occupancy", occupancy, mdl_occ());
   end

   task automatic cyc(input logic w, input logic f, input logic iv, input logic rw,
                      input logic [RA-1:0] d, input logic [RS-1:0] r, input logic z, input logic ov);
      we = w; flush = f; in_valid = iv; regwrite_mult_in = rw;
      wreg_in = d; pre_result = r; pre_zero = z; pre_overflow = ov;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic stall();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_hazard", hazard, 0);
      chk("rst_result", m_result, 0);
      reset = 1'b1;

      // single instruction, latency 3
      cyc(1, 0, 1, 1, 7, 32'h15, 0, 0);
      chk("t1_occ_e0", occupancy, 1);
      for (int i = 1; i <= 3; i++) begin
         idle();
         chk("t1_occ", occupancy, 1);
         chk("t1_out_valid", out_valid, (i == 3));
      end
      chk("t1_regwrite", regwrite_out, 1);
      chk("t1_dst", dst_reg, 7);
      chk("t1_result", m_result, 32'h15);
      idle();
      chk("t1_occ_retired", occupancy, 0);
      chk("t1_out_gone", out_valid, 0);

      // back-to-back, stall, order
      for (int i = 1; i <= 4; i++)
         cyc(1, 0, 1, 1, 5'(i), 32'h100 + 32'(i), i[0], i[1]);
      chk("t2_occ_full", occupancy, 4);
      chk("t2_dst_first", dst_reg, 1);
      chk("t2_zero", zero, 1);
      chk("t2_ovf", overflow, 0);
      for (int s = 0; s < 2; s++) begin
         stall();
         chk("t2_stall_occ", occupancy, 4);
         chk("t2_stall_dst", dst_reg, 1);
         chk("t2_stall_res", m_result, 32'h101);
      end
      for (int i = 2; i <= 4; i++) begin
         idle();
         chk("t2_order_dst", dst_reg, 64'(i));
         chk("t2_order_vld", out_valid, 1);
      end
      idle();
      chk("t2_drained_vld", out_valid, 0);
      chk("t2_drained_occ", occupancy, 0);

      // hazard
      cyc(1, 0, 1, 1, 9, 32'h9, 0, 0);
      cyc(1, 0, 1, 1, 0, 32'h0, 0, 0);
      stall();
      src_a = 9; src_b = 5;
      #1 chk("t3_haz_a", hazard, 1);
      src_a = 3; src_b = 9;
      #1 chk("t3_haz_b", hazard, 1);
      src_a = 0; src_b = 0;
      #1 chk("t3_haz_r0", hazard, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 9, 32'h9, 0, 0);
      stall();
      src_a = 9;
      #1 chk("t3_haz_norw", hazard, 0);
      src_a = 0;
      cyc(1, 1, 0, 0, 0, 0, 0, 0);

      // flush beats a valid input
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 5'(10 + i), 32'(i), 0, 0);
      chk("t4_occ3", occupancy, 3);
      cyc(1, 1, 1, 1, 13, 32'hD, 0, 0);
      chk("t4_occ", occupancy, 0);
      chk("t4_vld", out_valid, 0);
      chk("t4_rw", regwrite_out, 0);
      src_a = 13; src_b = 12;
      #1 chk("t4_haz", hazard, 0);
      src_a = 0; src_b = 0;
      for (int i = 0; i < 4; i++) begin
         idle();
         chk("t4_not_captured", out_valid, 0);
      end

      // asynchronous reset while full
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, 5'(20 + i), 32'hA0 + 32'(i), 1, 1);
      chk("t5_occ_full", occupancy, 4);
      src_a = 23;
      #1 chk("t5_haz_pre", hazard, 1);
      we = 1; in_valid = 0; regwrite_mult_in = 0;
      reset = 1'b0;
      #1;
      chk("t5_rst_vld", out_valid, 0);
      chk("t5_rst_occ", occupancy, 0);
      chk("t5_rst_dst", dst_reg, 0);
      chk("t5_rst_res", m_result, 0);
      chk("t5_rst_zero", zero, 0);
      chk("t5_rst_haz", hazard, 0);
      reset = 1'b1;
      src_a = 0;
      @(posedge clk);
      #2;
      chk("t5_empty", occupancy, 0);
      cyc(1, 0, 1, 1, 25, 32'hABC, 0, 0);
      idle();
      idle();
      chk("t5_not_yet", out_valid, 0);
      idle();
      chk("t5_reemerge", out_valid, 1);
      chk("t5_dst", dst_reg, 25);
      chk("t5_res", m_result, 32'hABC);
      idle();

      // alternating bubbles
      src_a = 31;
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) cyc(1, 0, 1, 1, 3, 32'(k), 0, 0);
         else            cyc(1, 0, 0, 1, 31, 32'(k), 1, 1);
         if (k >= 2) chk("t6_occ", occupancy, 2);
         if (k >= 3) begin
            chk("t6_vld", out_valid, ((k - 3) % 2 == 0));
            chk("t6_rw", regwrite_out, ((k - 3) % 2 == 0));
         end
         chk("t6_bubble_haz", hazard, 0);
      end
      src_a = 0;
      idle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
